// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared state encoding, defaults and round-robin search for mult_rr_sched
package mult_sched_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns {found, id}: first set bit of req at ptr, ptr+1, ... modulo n (n <= 8).
   // Scanning from the far end lets the nearest hit overwrite earlier ones.
   function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
      logic [3:0] r;
      logic [2:0] idx;
      r = '0;
      for (int k = 7; k >= 0; k--) begin
         idx = 3'((int'(ptr) + k) % n);
         if (k < n && req[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

endpackage

// File: rtl/mult_rr_sched_rr_arbiter.sv
// rtl/mult_rr_sched_rr_arbiter.sv - combinational round-robin grant from request vector and pointer
module rr_arbiter
   import mult_sched_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  id,
   output logic            any
);

   logic [3:0] pick;

   always_comb begin
      pick  = rr_pick(8'(req), 3'(ptr), NREQ);
      any   = pick[3];
      id    = pick[IDW-1:0];
      grant = '0;
      if (pick[3]) grant[id] = 1'b1;
   end

endmodule

// File: rtl/mult_rr_sched.sv
// rtl/mult_rr_sched.sv - round-robin shared shift-add multiplier; MULT_ZERO_SKIP_EN short-cuts zero operands
module mult_rr_sched
   import mult_sched_pkg::*;
#(
   parameter  int NREQ  = DEF_NREQ,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*WIDTH-1:0]    rsp_product,
   output logic [IDW-1:0]        rsp_id,
   output logic                  busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t               state;
   logic [IDW-1:0]       ptr;
   logic [2*WIDTH-1:0]   acc;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [IDW-1:0]       id_q;

   logic [NREQ-1:0]      grant;
   logic [IDW-1:0]       gid;
   logic                 any;
   logic [WIDTH-1:0]     a_sel, b_sel;
   logic [2*WIDTH-1:0]   pp;
   logic [IDW-1:0]       ptr_next;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .id    (gid),
      .any   (any)
   );

   assign req_ready = (state == IDLE) ? grant : '0;
   assign a_sel     = req_a[gid*WIDTH +: WIDTH];
   assign b_sel     = req_b[gid*WIDTH +: WIDTH];
   assign ptr_next  = (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;
   assign pp        = {{WIDTH{1'b0}}, a_q & {WIDTH{b_q[cnt]}}} << cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= '0;
         acc         <= '0;
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid   <= 1'b0;
         rsp_product <= '0;
         rsp_id      <= '0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any) begin
                  a_q  <= a_sel;
                  b_q  <= b_sel;
                  id_q <= gid;
                  acc  <= '0;
                  cnt  <= '0;
                  ptr  <= ptr_next;
                  busy <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
                  // Zero operand: product is known, rsp_valid rises on the following edge.
                  if (a_sel == '0 || b_sel == '0) begin
                     state       <= DONE;
                     rsp_product <= '0;
                     rsp_id      <= gid;
                  end else begin
                     state <= MUL;
                  end
`else
                  state <= MUL;
`endif
               end
            end
            MUL: begin
               acc <= acc + pp;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) begin
                  state       <= DONE;
                  rsp_valid   <= 1'b1;
                  rsp_product <= acc + pp;
                  rsp_id      <= id_q;
               end
            end
            DONE: begin
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_rr_sched.sv
// tb/tb_mult_rr_sched.sv - directed vector bench for mult_rr_sched
module tb_mult_rr_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_product;
   logic [1:0]  rsp_id;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   mult_rr_sched dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_product (rsp_product),
      .rsp_id      (rsp_id),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  rv;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  ready;
      logic [1:0]  id;
      logic [7:0]  prod;
      bit          zop;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int exp_lat(input bit zop);
`ifdef MULT_ZERO_SKIP_EN
      return zop ? 1 : 4;
`else
      return 4;
`endif
   endfunction

   task automatic run_txn(input logic [3:0] rv, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] er, input logic [1:0] eid, input logic [7:0] ep,
                          input bit zop, input string nm);
      int lat;
      req_valid = rv;
      req_a     = a;
      req_b     = b;
      #1;
      chk({nm, " req_ready"}, 32'(req_ready), 32'(er));
      tick();
      req_valid = '0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat(zop)));
      chk({nm, " product"}, 32'(rsp_product), 32'(ep));
      chk({nm, " id"}, 32'(rsp_id), 32'(eid));
      chk({nm, " busy"}, 32'(busy), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({nm, " rsp_valid cleared"}, 32'(rsp_valid), 32'd0);
      chk({nm, " busy cleared"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int w;
      int last_cyc;
      int lat;
      bit seen;
      logic [7:0] rr_prod [4];

      vecs[0] = '{4'b0010, 16'h0070, 16'h0090, 4'b0010, 2'd1, 8'd63,  1'b0};
      vecs[1] = '{4'b1111, 16'hFFFF, 16'hFFFF, 4'b0100, 2'd2, 8'd225, 1'b0};
      vecs[2] = '{4'b0011, 16'h000F, 16'h0000, 4'b0001, 2'd0, 8'd0,   1'b1};
      vecs[3] = '{4'b1001, 16'hC000, 16'hD000, 4'b1000, 2'd3, 8'd156, 1'b0};
      vecs[4] = '{4'b0100, 16'h0000, 16'h0500, 4'b0100, 2'd2, 8'd0,   1'b1};
      vecs[5] = '{4'b1000, 16'h1000, 16'h1000, 4'b1000, 2'd3, 8'd1,   1'b0};

      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_product", 32'(rsp_product), 32'd0);
      chk("reset rsp_id", 32'(rsp_id), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++)
         run_txn(vecs[i].rv, vecs[i].a, vecs[i].b, vecs[i].ready, vecs[i].id,
                 vecs[i].prod, vecs[i].zop, $sformatf("vec%0d", i));

      // All four requesting with the consumer always ready: strict rotation, 6-cycle spacing.
      rr_prod[0] = 8'd3; rr_prod[1] = 8'd12; rr_prod[2] = 8'd25; rr_prod[3] = 8'd42;
      req_a     = {4'd6, 4'd5, 4'd4, 4'd3};
      req_b     = {4'd7, 4'd5, 4'd3, 4'd1};
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      last_cyc = 0;
      for (int g = 0; g < 5; g++) begin
         w = 0;
         while (req_ready == '0 && w < 20) begin
            tick();
            w++;
         end
         chk($sformatf("rr grant %0d", g), 32'(req_ready), 32'(4'b0001 << (g % 4)));
         if (g > 0) chk($sformatf("rr spacing %0d", g), 32'(cyc - last_cyc), 32'd6);
         last_cyc = cyc;
         tick();
         w = 0;
         while (!rsp_valid && w < 20) begin
            tick();
            w++;
         end
         chk($sformatf("rr product %0d", g), 32'(rsp_product), 32'(rr_prod[g % 4]));
         chk($sformatf("rr id %0d", g), 32'(rsp_id), 32'(g % 4));
      end
      req_valid = '0;
      tick();
      rsp_ready = 1'b0;
      chk("rr drained", 32'(rsp_valid), 32'd0);

      // Consumer stalls in DONE for 10 cycles while everyone else waits.
      req_valid = 4'b0001;
      req_a     = 16'h000F;
      req_b     = 16'h000F;
      #1;
      chk("bp grant", 32'(req_ready), 32'(4'b0001));
      tick();
      req_valid = 4'b1111;
      w = 0;
      while (!rsp_valid && w < 20) begin
         tick();
         w++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("bp rsp_valid held", 32'(rsp_valid), 32'd1);
         chk("bp product held", 32'(rsp_product), 32'd225);
         chk("bp id held", 32'(rsp_id), 32'd0);
         chk("bp req_ready blocked", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("bp rsp_valid after handshake", 32'(rsp_valid), 32'd0);
      chk("bp product kept", 32'(rsp_product), 32'd225);
      chk("bp accept resumes", 32'(req_ready), 32'(4'b0010));
      req_valid = '0;
      tick();

      // Reset while the multiplier is on its third row: the operation vanishes.
      req_valid = 4'b0100;
      req_a     = 16'h0500;
      req_b     = 16'h0600;
      #1;
      chk("abort grant", 32'(req_ready), 32'(4'b0100));
      tick();
      req_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      chk("abort no response", 32'(seen), 32'd0);
      run_txn(4'b1111, 16'h000B, 16'h000E, 4'b0001, 2'd0, 8'd154, 1'b0, "post-reset");

      // Requester 3 withdraws before being granted; requester 1 wins.
      run_txn(4'b0010, 16'h0020, 16'h0030, 4'b0010, 2'd1, 8'd6, 1'b0, "ptr-to-2");
      req_valid = 4'b1010;
      req_a     = 16'h0090;
      req_b     = 16'h0080;
      #1;
      chk("drop pre grant", 32'(req_ready), 32'(4'b1000));
      run_txn(4'b0010, 16'h0090, 16'h0080, 4'b0010, 2'd1, 8'd72, 1'b0, "drop");
      req_valid = 4'b1111;
      #1;
      chk("drop ptr", 32'(req_ready), 32'(4'b0100));
      req_valid = '0;

      // Zero operand latency on a fresh requester.
      tick();
      req_valid = 4'b0100;
      req_a     = 16'h0F00;
      req_b     = 16'h0000;
      #1;
      tick();
      req_valid = '0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("zero latency", 32'(lat), 32'(exp_lat(1'b1)));
      chk("zero product", 32'(rsp_product), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mult_rr_sched.md
Name: mult_rr_sched

Overview:
- Shares one sequential shift-add unsigned multiplier among NREQ requesters using round-robin arbitration.
- Each requester presents operands over a valid/ready handshake. The block builds the product one partial-product row per clock and returns it with the winning requester's ID over a valid/ready response channel.
- Sits between requesting client blocks and the arithmetic datapath. It replaces per-client combinational multipliers where area matters more than latency.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.
- IDW, $clog2(NREQ), width of the requester ID (derived; not overridden).

Ports:
- clk  in  1  single clock; everything is registered on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has operands.
- req_ready  out  NREQ  bit i: requester i is accepted this cycle; one-hot or zero.
- req_a  in  NREQ*WIDTH  packed multiplicands; slice i is [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed multipliers, same packing.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_product  out  2*WIDTH  unsigned a*b.
- rsp_id  out  IDW  index of the requester that owns rsp_product.
- busy  out  1  high in MUL and DONE.

Behaviour:
- States: IDLE, MUL, DONE.
- Reset: state=IDLE, rr pointer=0, accumulator=0, step count=0. Outputs: rsp_valid=0, rsp_product=0, rsp_id=0, busy=0, req_ready=0.
- Reset mid-operation abandons the operation. No response is produced for it.
- IDLE grant:
  - Grant is combinational from req_valid and the pointer: first set bit searching i = ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready is high only for the granted bit, and only in IDLE.
- IDLE accept edge (any req_valid set):
  - Latch a, b and the ID.
  - Accumulator=0, count=0, state=MUL.
  - ptr = (granted ID + 1) mod NREQ.
- MUL, each edge:
  - acc += ({WIDTH{b[count]}} & a) << count, computed in 2*WIDTH bits; overflow is impossible.
  - count++. On the edge where count==WIDTH-1, go to DONE.
- Latency: operands accepted at edge k; rsp_valid is high after edge k+WIDTH (4 cycles at default).
- DONE:
  - rsp_valid=1. rsp_product and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that edge: state=IDLE, rsp_valid=0. rsp_product and rsp_id keep their last value.
  - No new accept occurs in the same cycle as the response handshake. Minimum issue interval is WIDTH+2 cycles.
- Backpressure:
  - Requests arriving during MUL or DONE see req_ready=0 and must hold.
  - A requester may drop valid before being granted; the grant is recomputed every IDLE cycle.
- The pointer does not move when no request is accepted.
- No req_valid in IDLE: state stays IDLE, all outputs are unchanged.

Optional Feature:
- MULT_ZERO_SKIP_EN defined:
  - If the granted a==0 or b==0 at the accept edge, go directly IDLE->DONE with product 0.
  - rsp_valid is high after edge k+1.
  - Pointer update is unchanged.
- Undefined: every operation takes the full WIDTH MUL cycles.

Decomposition:
- Package mult_sched_pkg holds:
  - the state enum (IDLE/MUL/DONE) and its 2-bit encoding;
  - the default NREQ/WIDTH constants;
  - a function for the round-robin first-set search.
- One sub-module, rr_arbiter:
  - inputs: request vector, pointer;
  - outputs: one-hot grant, encoded ID, any-grant;
  - purely combinational; the pointer register stays in mult_rr_sched.

Test Plan:
- Reset, then a single request: req_valid=4'b0010, a=7, b=9 -> req_ready=4'b0010 for one cycle; after 4 edges rsp_valid=1, rsp_product=63, rsp_id=1; ptr becomes 2.
- All four request continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each product is correct; one response per 6 cycles.
- Extreme operands a=15, b=15 -> rsp_product=225. Also a=15, b=0 -> 0 after 4 MUL cycles (macro off) or 1 cycle (MULT_ZERO_SKIP_EN).
- rsp_ready held low for 10 cycles in DONE -> rsp_valid, rsp_product and rsp_id stable; req_ready stays 0 throughout; accept resumes the cycle after the handshake.
- rst asserted in MUL with count=2 -> next cycle state IDLE, rsp_valid=0, ptr=0; no response for the aborted operation; a fresh request completes correctly.
- Requester 3 drops valid before grant while requester 1 is valid and ptr=2 -> requester 1 is granted; ptr becomes 2.
